sub_layer_mc: RTL and testbench
===============================

Name: sub_layer_mc

Overview:
- Nios II multicycle custom instruction. Performs the forward 4-bit S-box layer of the cipher on a 32-bit word, with an optional round-key add first.
- Computes result = S(dataa XOR datab) nibble-wise, using one shared S-box lookup iterated over the 8 nibbles.
- Complements the combinational inverse-substitution helper. For any nibble x, applying the inverse helper to S(x) must return x.

Parameters:
- NIBBLES, 8, number of 4-bit nibbles processed per word. Fixed at 8 for 32-bit operands. Sets the counter terminal value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clk_en  input  1  Nios clock enable. When low, all state holds.
- start  input  1  one-cycle request pulse from the CPU.
- dataa  input  32  plaintext/state word.
- datab  input  32  round key; XORed into dataa before substitution (0 = plain S-box layer).
- done  output  1  one-cycle completion pulse.
- result  output  32  substituted word.

Behaviour:
- Forward S-box, as input->output hex: 0->c 1->9 2->d 3->2 4->5 5->f 6->3 7->8 8->7 9->e a->0 b->1 c->a d->4 e->b f->6.
- This table is the exact inverse of the team's inverse-S-box helper table.
- Reset (reset_n low, asynchronous): state=IDLE, nibble counter=0, working register=0, result=0x00000000, done=0. Reset mid-operation aborts; no done is produced.
- Every transition below requires clk_en=1. With clk_en=0, state, counter, working register, result and done all hold.
- IDLE: when start=1, load work=dataa^datab, cnt=0, go to BUSY. done=0.
- BUSY: each edge replaces work[4*cnt+3:4*cnt] with S(that nibble). Nibble 0 (bits 3:0) goes first. cnt increments.
- BUSY exit: on the edge that processes cnt=NIBBLES-1, result is loaded with the fully substituted word, done is set to 1, and state goes to DONE.
- DONE: lasts one cycle. done returns to 0 on the next enabled edge and state returns to IDLE.
- start in DONE is ignored; the CPU must wait for IDLE.
- start in BUSY is ignored. dataa/datab changes during BUSY have no effect, because the operands are latched at start.
- Latency: start sampled at edge E0; done is high in the cycle following edge E8, i.e. 8 enabled cycles after the start edge.
- Throughput: one operation per 10 enabled cycles.
- result holds its value until the next completion or reset. It is never partially updated: intermediate nibble results are not visible on result.
- Counter is 3 bits and wraps 7->0 on BUSY exit; no overflow condition exists.
- done is registered (glitch-free) and is high for exactly one enabled cycle per accepted start.

Test Plan:
- Reset: hold reset_n=0 mid-BUSY -> done=0, result=0x00000000. After release, idle with no spurious done.
- dataa=0x00000000, datab=0 -> after 8 cycles, done pulses once and result=0xCCCCCCCC.
- dataa=0x76543210, datab=0 -> result=0x83F52D9C. dataa=0xFEDCBA98, datab=0 -> result=0x6B4A10E7.
- Key add: dataa=0xFFFFFFFF, datab=0xFFFFFFFF -> result=0xCCCCCCCC. Second start pulse during BUSY -> ignored, only one done.
- clk_en toggled low for 3 cycles mid-BUSY -> done delayed by exactly 3 cycles, same result value.
- Round trip: random dataa with datab=0 -> each result nibble through the inverse helper equals the original nibble. Cover all 16 nibble values at least once.

Source files
------------

// File: rtl/sub_layer_mc.sv
// Nios II multicycle custom instruction: forward 4-bit S-box layer over a 32-bit word,
// with an optional round-key XOR applied first. One shared S-box is iterated across the nibbles.
module sub_layer_mc #(
  parameter int unsigned NIBBLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned   CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   work, work_nx;
  logic          load, step, finish;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hc;  4'h1: y = 4'h9;  4'h2: y = 4'hd;  4'h3: y = 4'h2;
      4'h4: y = 4'h5;  4'h5: y = 4'hf;  4'h6: y = 4'h3;  4'h7: y = 4'h8;
      4'h8: y = 4'h7;  4'h9: y = 4'he;  4'ha: y = 4'h0;  4'hb: y = 4'h1;
      4'hc: y = 4'ha;  4'hd: y = 4'h4;  4'he: y = 4'hb;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    state <= IDLE;
    else if (clk_en) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && start;
    step   = (state == BUSY);
    finish = step && (cnt == LAST);
  end

  // Only the nibble selected by cnt passes through the shared S-box this cycle.
  always_comb begin
    work_nx = work;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) work_nx[4*i +: 4] = sbox(work[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work   <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      done <= finish;
      if (load) begin
        work <= dataa ^ datab;
        cnt  <= '0;
      end else if (step) begin
        work <= work_nx;
        cnt  <= cnt + 1'b1;
      end
      if (finish) result <= work_nx;
    end
  end

endmodule

// File: tb/tb_sub_layer_mc.sv
// Scoreboard bench for sub_layer_mc: stimulus pushes expected results, a monitor pops on done.
module tb_sub_layer_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        done;
  logic [31:0] result;

  sub_layer_mc #(.NIBBLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] FWD [16] = '{4'hc, 4'h9, 4'hd, 4'h2, 4'h5, 4'hf, 4'h3, 4'h8,
                                      4'h7, 4'he, 4'h0, 4'h1, 4'ha, 4'h4, 4'hb, 4'h6};
  localparam logic [3:0] INV [16] = '{4'ha, 4'hb, 4'h3, 4'h6, 4'hd, 4'h4, 4'hf, 4'h8,
                                      4'h7, 4'h1, 4'hc, 4'he, 4'h0, 4'h2, 4'h9, 4'h5};

  typedef struct {
    logic [31:0] res;
    logic [31:0] a;
    bit          rt;
    int          start_edge;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edges = 0;
  bit          en_at_edge = 1'b0;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] ref_sub(input logic [31:0] x);
    logic [31:0] y;
    logic [3:0]  n;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      n = x[4*k +: 4];
      y[4*k +: 4] = FWD[n];
    end
    return y;
  endfunction

  function automatic logic [31:0] inv_word(input logic [31:0] x);
    logic [31:0] y;
    logic [3:0]  n;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      n = x[4*k +: 4];
      y[4*k +: 4] = INV[n];
    end
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edges++;
    en_at_edge = clk_en;
  end

  // Monitor: a fresh done is one seen after an enabled edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done && en_at_edge) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", 32'(edges - e.start_edge), 32'(e.lat));
        if (e.rt) check("roundtrip", inv_word(result), e.a);
        last_res = e.res;
      end
    end else if (reset_n && !done) begin
      check("result_hold", result, last_res);
    end
  end

  // Called at posedge+1; start is sampled by the next edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len, input bit restart);
    exp_t e;
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = a;
    datab  = b;
    e.res = ref_sub(a ^ b);
    e.a = a;
    e.rt = (b == 0);
    e.start_edge = edges + 1;
    e.lat = 8 + stall_len;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    dataa = $urandom;
    datab = $urandom;
    for (int t = 0; t < 60 && sb.size() != 0; t++) begin
      clk_en = !(t >= stall_at && t < stall_at + stall_len);
      start  = restart && (t == 2);
      @(posedge clk); #1;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    if (sb.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    int sa, sl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    run_op(32'h00000000, 32'h00000000, 0, 0, 1'b0);
    run_op(32'h76543210, 32'h00000000, 0, 0, 1'b0);
    run_op(32'hFEDCBA98, 32'h00000000, 0, 0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b1);
    run_op(32'h12345678, 32'h00000000, 3, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0;
      sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      sa = int'($urandom_range(1, 5));
      run_op(a, b, sa, sl, $urandom_range(0, 3) == 0);
    end

    // Reset mid-BUSY: aborts, no done afterwards.
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = $urandom;
    datab  = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    reset_n  = 1'b0;
    last_res = 32'h0;
    @(negedge clk);
    check("midbusy_reset_done", 32'(done), 32'd0);
    check("midbusy_reset_result", result, 32'h0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (14) @(posedge clk); #1;

    run_op(32'hA5C3F00F, 32'h0F0F0F0F, 0, 0, 1'b0);
    repeat (15) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
